pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Applies the hazard and forwarding decisions of the hazard detection unit to the five-stage MIPS redirect pipeline. Converts the combinational `stall` and register-match flags into PC and pipeline-register enables, bubble and flush pulses, and registered forwarding-mux selects for the EX stage. Tracks per-stage valid bits and a halt state, with optional performance counters. It sits between the hazard detection unit and the datapath pipeline registers.

## Interface
- `CNT_W`, 32: width of each performance counter.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `stall` input 1: load-use hazard request from the hazard detection unit.
- `ALUaeq` / `ALUbeq` input 1: ID operand A / B matches the EX-stage destination.
- `MEMaeq` / `MEMbeq` input 1: ID operand A / B matches the MEM-stage destination.
- `src1ex` / `src1mem` input 1: ID src1 matches the EX / MEM destination, used for ID-stage branch compare.
- `rfd2alueq` / `rfd2dmeq` input 1: ID src2 matches the EX / MEM destination.
- `redirect` input 1: a taken branch or jump resolved in ID.
- `wb_halt` input 1: syscall-halt instruction in WB.
- `pc_en` output 1: PC write enable.
- `ifid_en` output 1: IF/ID register enable.
- `ifid_flush` output 1: IF/ID register clear.
- `idex_flush` output 1: inserts a bubble into ID/EX.
- `fwd_a_sel` / `fwd_b_sel` output 2: EX ALU operand select. 00 = register file, 01 = EX/MEM, 10 = MEM/WB.
- `fwd_id1_sel` / `fwd_id2_sel` output 2: ID compare operand select, same encoding, combinational.
- `ex_valid` / `mem_valid` / `wb_valid` output 1: stage holds a real instruction.
- `halted` output 1: pipeline frozen.
- `stall_cnt` / `flush_cnt` / `fwd_cnt` output CNT_W: performance counters.

## Operation
- State machine with two states, RUN and HALT. The reset state is RUN.
  - RUN → HALT when `wb_halt` & `wb_valid`.
  - HALT is left only by reset.
- Behaviour in RUN, by priority:
  - `redirect` (highest): `ifid_flush`=1, `pc_en`=1, `ifid_en`=1, `idex_flush`=0.
  - `stall`: `pc_en`=0, `ifid_en`=0, `idex_flush`=1.
  - Otherwise: `pc_en`=`ifid_en`=1, both flushes 0.
  - If `redirect` and `stall` are both high: the redirect wins and no stall is counted.
- Behaviour in HALT:
  - `pc_en`=`ifid_en`=0 and both flushes are 0.
  - All stage registers inside this block hold their values.
- ID-stage selects, combinational:
  - `fwd_id1_sel` = `src1ex` ? 01 : `src1mem` ? 10 : 00.
  - `fwd_id2_sel` = `rfd2alueq` ? 01 : `rfd2dmeq` ? 10 : 00.
- EX-stage selects, registered on each edge in RUN:
  - `fwd_a_sel` ← `idex_flush` ? 00 : `ALUaeq` ? 01 : `MEMaeq` ? 10 : 00. `fwd_b_sel` is computed the same way from `ALUbeq` / `MEMbeq`.
  - The EX-stage match has priority over the MEM-stage match, because EX holds the younger producer.
- Valid chain:
  - `ex_valid` ← ~`idex_flush`.
  - `mem_valid` ← `ex_valid`.
  - `wb_valid` ← `mem_valid`.
- Counters, all saturating at 2^CNT_W−1:
  - `stall_cnt` +1 per cycle in RUN with `stall` & ~`redirect`.
  - `flush_cnt` +1 per `redirect` cycle.
  - `fwd_cnt` +1 per edge that loads a nonzero `fwd_a_sel` or `fwd_b_sel`; it adds 1 even when both are nonzero.

## Timing
- Reset values:
  - Registered outputs: `fwd_a_sel` = `fwd_b_sel` = 00, all valids 0, `halted`=0, counters 0.
  - Combinational enables while `rst_n`=0: `pc_en`=`ifid_en`=0 and flushes 0.
- Enables and ID selects are combinational, with zero latency from their inputs.
- EX selects and valids have one cycle of latency. The select applies to the instruction that enters EX on that edge.
- A load-use `stall` produces exactly one bubble:
  - The next cycle, the load is in MEM, so the hazard unit deasserts `stall`.
  - If `stall` is held, a bubble is inserted every cycle it stays high.
- `halted` rises on the edge after `wb_halt` & `wb_valid` is sampled.
- Reset asserted mid-stall or in HALT: RUN immediately, with outputs at reset values.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: the three counters are instantiated and behave as specified above.
- `HAZARD_PERF_CNT_EN` undefined: there is no counter logic, and `stall_cnt`, `flush_cnt` and `fwd_cnt` are tied to 0.
- All other behaviour is identical in both builds.

## Structure
- Shared package `hazard_pkg` holds:
  - The state type (RUN, HALT).
  - Forwarding-select constants: FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
- Sub-module `sat_counter`: a parameterised-width saturating counter with an increment enable and asynchronous active-low reset. It is instantiated three times under the macro.

## Test plan
- Load-use: `stall`=1 for 1 cycle → `pc_en`=0, `ifid_en`=0, `idex_flush`=1 that cycle; the next `ex_valid`=0; `stall_cnt`=1.
- EX forward: `ALUaeq`=1 and `MEMaeq`=1 together → `fwd_a_sel`=01 after the edge. With only `MEMbeq`=1 → `fwd_b_sel`=10. `fwd_cnt` +1 per such edge.
- Stall plus redirect in the same cycle → `ifid_flush`=1, `pc_en`=1, `idex_flush`=0; `stall_cnt` unchanged, `flush_cnt`=1.
- ID compare: `src1ex`=1, `src1mem`=1 → `fwd_id1_sel`=01. `rfd2dmeq`=1 alone → `fwd_id2_sel`=10, in the same cycle.
- Halt: `wb_halt`=1 with `wb_valid`=1 → `halted`=1 next cycle and `pc_en`=0. Further `stall`/`redirect` pulses have no effect. `rst_n` low → RUN with all outputs at reset values.
- Saturation with the macro defined and CNT_W=4: hold `stall` for 20 cycles → `stall_cnt`=15. Without the macro → `stall_cnt`=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the RUN/HALT state encoding, the forwarding-select codes and the
// priority pick used by both the ID-stage and EX-stage forwarding muxes.
package hazard_pkg;

  typedef logic [0:0] state_t;
  localparam state_t RUN  = 1'b0;
  localparam state_t HALT = 1'b1;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;

  // The EX-stage producer is younger than the MEM-stage one, so it wins.
  function automatic fwd_sel_t fwd_pick(input logic i_ex_hit, input logic i_mem_hit);
    if (i_ex_hit) return FWD_EXMEM;
    if (i_mem_hit) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Parameterised saturating up-counter with increment enable.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count up on each enabled edge until all ones.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the five-stage MIPS redirect pipeline.
// Turns stall/redirect/match flags into PC and IF/ID enables, bubble and
// flush pulses, ID and EX forwarding selects, a stage valid chain and a
// RUN/HALT state. Performance counters exist only when HAZARD_PERF_CNT_EN
// is defined; otherwise they read as zero.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             ALUaeq,
  input  logic             ALUbeq,
  input  logic             MEMaeq,
  input  logic             MEMbeq,
  input  logic             src1ex,
  input  logic             src1mem,
  input  logic             rfd2alueq,
  input  logic             rfd2dmeq,
  input  logic             redirect,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [1:0]       fwd_id1_sel,
  output logic [1:0]       fwd_id2_sel,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] fwd_cnt
);

  state_t   r_state;
  fwd_sel_t r_fwd_a;
  fwd_sel_t r_fwd_b;
  logic     r_ex_valid;
  logic     r_mem_valid;
  logic     r_wb_valid;

  logic     w_in_run;
  logic     w_run;
  logic     w_redirect;
  logic     w_bubble;
  fwd_sel_t w_fwd_a_nxt;
  fwd_sel_t w_fwd_b_nxt;

  // NOTE: the enables are gated with rst_n so they read as zero during reset,
  // not only after the first edge; the registers alone cannot provide that.
  assign w_in_run   = (r_state == RUN);
  assign w_run      = rst_n && w_in_run;
  assign w_redirect = w_run && redirect;
  assign w_bubble   = w_run && stall && !redirect;

  assign pc_en      = w_run && !w_bubble;
  assign ifid_en    = w_run && !w_bubble;
  assign ifid_flush = w_redirect;
  assign idex_flush = w_bubble;

  assign fwd_id1_sel = fwd_pick(src1ex, src1mem);
  assign fwd_id2_sel = fwd_pick(rfd2alueq, rfd2dmeq);

  // A bubble entering EX must not forward anything.
  assign w_fwd_a_nxt = w_bubble ? FWD_RF : fwd_pick(ALUaeq, MEMaeq);
  assign w_fwd_b_nxt = w_bubble ? FWD_RF : fwd_pick(ALUbeq, MEMbeq);

  // RUN/HALT state: a halt instruction retiring in WB freezes the pipe until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else if (w_in_run && wb_halt && r_wb_valid) begin
      r_state <= HALT;
    end
  end

  // EX selects and valid chain advance only in RUN; in HALT they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_a     <= FWD_RF;
      r_fwd_b     <= FWD_RF;
      r_ex_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_wb_valid  <= 1'b0;
    end else if (w_in_run) begin
      r_fwd_a     <= w_fwd_a_nxt;
      r_fwd_b     <= w_fwd_b_nxt;
      r_ex_valid  <= !w_bubble;
      r_mem_valid <= r_ex_valid;
      r_wb_valid  <= r_mem_valid;
    end
  end

  assign fwd_a_sel = r_fwd_a;
  assign fwd_b_sel = r_fwd_b;
  assign ex_valid  = r_ex_valid;
  assign mem_valid = r_mem_valid;
  assign wb_valid  = r_wb_valid;
  assign halted    = (r_state == HALT);

`ifdef HAZARD_PERF_CNT_EN
  logic w_fwd_inc;

  // One count per loading edge, even when both operands forward.
  assign w_fwd_inc = w_run && ((w_fwd_a_nxt != FWD_RF) || (w_fwd_b_nxt != FWD_RF));

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_bubble),
    .o_cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_redirect),
    .o_cnt (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fwd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_fwd_inc),
    .o_cnt (fwd_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. A behavioural model tracks
// the pipeline (halt flag, per-stage valid shift, EX selects, counters) and
// every cycle is compared against it; directed scenarios add spot checks.
// Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic stall = 1'b0, ALUaeq = 1'b0, ALUbeq = 1'b0, MEMaeq = 1'b0, MEMbeq = 1'b0;
  logic src1ex = 1'b0, src1mem = 1'b0, rfd2alueq = 1'b0, rfd2dmeq = 1'b0;
  logic redirect = 1'b0, wb_halt = 1'b0;

  logic             pc_en, ifid_en, ifid_flush, idex_flush;
  logic [1:0]       fwd_a_sel, fwd_b_sel, fwd_id1_sel, fwd_id2_sel;
  logic             ex_valid, mem_valid, wb_valid, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, fwd_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit         m_halted;
  bit         m_valid [3];   // [0]=EX, [1]=MEM, [2]=WB
  logic [1:0] m_fa, m_fb;
  int         m_stall_cnt, m_flush_cnt, m_fwd_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .ALUaeq      (ALUaeq),
    .ALUbeq      (ALUbeq),
    .MEMaeq      (MEMaeq),
    .MEMbeq      (MEMbeq),
    .src1ex      (src1ex),
    .src1mem     (src1mem),
    .rfd2alueq   (rfd2alueq),
    .rfd2dmeq    (rfd2dmeq),
    .redirect    (redirect),
    .wb_halt     (wb_halt),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .fwd_id1_sel (fwd_id1_sel),
    .fwd_id2_sel (fwd_id2_sel),
    .ex_valid    (ex_valid),
    .mem_valid   (mem_valid),
    .wb_valid    (wb_valid),
    .halted      (halted),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .fwd_cnt     (fwd_cnt)
  );

  function automatic logic [1:0] pick(input logic ex_hit, input logic mem_hit);
    if (ex_hit) return 2'b01;
    if (mem_hit) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int bump(input int c);
`ifdef HAZARD_PERF_CNT_EN
    return (c < CNT_MAX) ? c + 1 : c;
`else
    return 0;
`endif
  endfunction

  task automatic set_idle();
    stall = 0; ALUaeq = 0; ALUbeq = 0; MEMaeq = 0; MEMbeq = 0;
    src1ex = 0; src1mem = 0; rfd2alueq = 0; rfd2dmeq = 0;
    redirect = 0; wb_halt = 0;
  endtask

  task automatic rand_inputs();
    stall     = ($urandom_range(0, 3) == 0);
    redirect  = ($urandom_range(0, 4) == 0);
    ALUaeq    = $urandom_range(0, 1); ALUbeq   = $urandom_range(0, 1);
    MEMaeq    = $urandom_range(0, 1); MEMbeq   = $urandom_range(0, 1);
    src1ex    = $urandom_range(0, 1); src1mem  = $urandom_range(0, 1);
    rfd2alueq = $urandom_range(0, 1); rfd2dmeq = $urandom_range(0, 1);
  endtask

  // One clock of stimulus: check combinational outputs mid-cycle, advance the
  // model at the edge, then check registered outputs and counters.
  task automatic run_cycle(input string tag);
    logic [7:0] exp_c;
    logic [7:0] exp_r;
    logic [1:0] nfa, nfb;
    bit         run, bub;
    @(negedge clk);
    run   = !m_halted;
    bub   = run && stall && !redirect;
    exp_c = {run && !bub, run && !bub, run && redirect, bub,
             pick(src1ex, src1mem), pick(rfd2alueq, rfd2dmeq)};
    n_vec++;
    if ({pc_en, ifid_en, ifid_flush, idex_flush, fwd_id1_sel, fwd_id2_sel} !== exp_c) begin
      n_err++;
      $display("FAIL %s comb: got %b required %b", tag,
               {pc_en, ifid_en, ifid_flush, idex_flush, fwd_id1_sel, fwd_id2_sel}, exp_c);
    end
    @(posedge clk);
    if (run) begin
      if (bub) m_stall_cnt = bump(m_stall_cnt);
      if (redirect) m_flush_cnt = bump(m_flush_cnt);
      nfa = bub ? 2'b00 : pick(ALUaeq, MEMaeq);
      nfb = bub ? 2'b00 : pick(ALUbeq, MEMbeq);
      if ((nfa != 2'b00) || (nfb != 2'b00)) m_fwd_cnt = bump(m_fwd_cnt);
      if (wb_halt && m_valid[2]) m_halted = 1'b1;
      m_valid[2] = m_valid[1];
      m_valid[1] = m_valid[0];
      m_valid[0] = !bub;
      m_fa = nfa;
      m_fb = nfb;
    end
    #1;
    exp_r = {m_fa, m_fb, m_valid[0], m_valid[1], m_valid[2], m_halted};
    n_vec++;
    if ({fwd_a_sel, fwd_b_sel, ex_valid, mem_valid, wb_valid, halted} !== exp_r) begin
      n_err++;
      $display("FAIL %s regs: got %b required %b", tag,
               {fwd_a_sel, fwd_b_sel, ex_valid, mem_valid, wb_valid, halted}, exp_r);
    end
    n_vec++;
    if ({stall_cnt, flush_cnt, fwd_cnt} !==
        {CNT_W'(m_stall_cnt), CNT_W'(m_flush_cnt), CNT_W'(m_fwd_cnt)}) begin
      n_err++;
      $display("FAIL %s counters: got %0d/%0d/%0d required %0d/%0d/%0d", tag,
               stall_cnt, flush_cnt, fwd_cnt, m_stall_cnt, m_flush_cnt, m_fwd_cnt);
    end
  endtask

  // Asynchronous reset with busy inputs; released just after a rising edge.
  task automatic test_reset(input string tag);
    rand_inputs();
    stall    = 1'b1;
    redirect = $urandom_range(0, 1);
    rst_n    = 1'b0;
    #1;
    m_halted = 0; m_valid[0] = 0; m_valid[1] = 0; m_valid[2] = 0;
    m_fa = 2'b00; m_fb = 2'b00;
    m_stall_cnt = 0; m_flush_cnt = 0; m_fwd_cnt = 0;
    n_vec++;
    if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b0000) begin
      n_err++;
      $display("FAIL %s enables: got %b required 0000", tag,
               {pc_en, ifid_en, ifid_flush, idex_flush});
    end
    n_vec++;
    if ({fwd_a_sel, fwd_b_sel, ex_valid, mem_valid, wb_valid, halted} !== 8'b0) begin
      n_err++;
      $display("FAIL %s regs: got %b required 00000000", tag,
               {fwd_a_sel, fwd_b_sel, ex_valid, mem_valid, wb_valid, halted});
    end
    n_vec++;
    if ({stall_cnt, flush_cnt, fwd_cnt} !== '0) begin
      n_err++;
      $display("FAIL %s counters: got %0d/%0d/%0d required 0/0/0", tag,
               stall_cnt, flush_cnt, fwd_cnt);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({ex_valid, halted, fwd_a_sel} !== 4'b0000) begin
      n_err++;
      $display("FAIL %s held: got %b required 0000", tag, {ex_valid, halted, fwd_a_sel});
    end
    rst_n = 1'b1;
    set_idle();
  endtask

  task automatic test_load_use();
    set_idle();
    stall = 1'b1;
    run_cycle("load_use_stall");
    n_vec++;
    if (ex_valid !== 1'b0) begin
      n_err++;
      $display("FAIL load_use_bubble: ex_valid got %b required 0", ex_valid);
    end
    n_vec++;
`ifdef HAZARD_PERF_CNT_EN
    if (stall_cnt !== CNT_W'(1)) begin
      n_err++;
      $display("FAIL load_use_cnt: stall_cnt got %0d required 1", stall_cnt);
    end
`else
    if (stall_cnt !== CNT_W'(0)) begin
      n_err++;
      $display("FAIL load_use_cnt: stall_cnt got %0d required 0", stall_cnt);
    end
`endif
    stall = 1'b0;
    run_cycle("load_use_resume");
    n_vec++;
    if (ex_valid !== 1'b1) begin
      n_err++;
      $display("FAIL load_use_resume: ex_valid got %b required 1", ex_valid);
    end
  endtask

  task automatic test_ex_forward();
    set_idle();
    ALUaeq = 1'b1; MEMaeq = 1'b1;
    run_cycle("ex_fwd_both");
    n_vec++;
    if (fwd_a_sel !== 2'b01) begin
      n_err++;
      $display("FAIL ex_fwd_prio: fwd_a_sel got %b required 01", fwd_a_sel);
    end
    set_idle();
    MEMbeq = 1'b1;
    run_cycle("ex_fwd_mem");
    n_vec++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0010) begin
      n_err++;
      $display("FAIL ex_fwd_mem: sel a/b got %b required 0010", {fwd_a_sel, fwd_b_sel});
    end
    set_idle();
    run_cycle("ex_fwd_none");
  endtask

  task automatic test_id_compare();
    set_idle();
    src1ex = 1'b1; src1mem = 1'b1; rfd2dmeq = 1'b1;
    #1;
    n_vec++;
    if ({fwd_id1_sel, fwd_id2_sel} !== 4'b0110) begin
      n_err++;
      $display("FAIL id_compare: id1/id2 got %b required 0110", {fwd_id1_sel, fwd_id2_sel});
    end
    run_cycle("id_compare");
  endtask

  task automatic test_stall_redirect();
    int flush_before;
    set_idle();
    flush_before = m_flush_cnt;
    stall = 1'b1; redirect = 1'b1;
    run_cycle("stall_redirect");
    n_vec++;
`ifdef HAZARD_PERF_CNT_EN
    if (flush_cnt !== CNT_W'(flush_before + 1)) begin
      n_err++;
      $display("FAIL stall_redirect_flush: flush_cnt got %0d required %0d",
               flush_cnt, flush_before + 1);
    end
`else
    if (flush_cnt !== CNT_W'(0)) begin
      n_err++;
      $display("FAIL stall_redirect_flush: flush_cnt got %0d required 0", flush_cnt);
    end
`endif
    set_idle();
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      rand_inputs();
      run_cycle("random");
    end
    set_idle();
  endtask

  task automatic test_halt();
    set_idle();
    for (int i = 0; i < 3; i++) run_cycle("halt_fill");
    wb_halt = 1'b1;
    run_cycle("halt_enter");
    n_vec++;
    if ({halted, pc_en} !== 2'b10) begin
      n_err++;
      $display("FAIL halt_enter: halted/pc_en got %b required 10", {halted, pc_en});
    end
    for (int i = 0; i < 12; i++) begin
      rand_inputs();
      wb_halt = $urandom_range(0, 1);
      run_cycle("halt_frozen");
    end
    test_reset("reset_in_halt");
    run_cycle("after_halt_reset");
    n_vec++;
    if ({halted, pc_en} !== 2'b01) begin
      n_err++;
      $display("FAIL halt_exit: halted/pc_en got %b required 01", {halted, pc_en});
    end
  endtask

  task automatic test_saturation();
    test_reset("reset_before_sat");
    stall = 1'b1;
    for (int i = 0; i < 20; i++) run_cycle("sat_stall");
    n_vec++;
`ifdef HAZARD_PERF_CNT_EN
    if (stall_cnt !== CNT_W'(CNT_MAX)) begin
      n_err++;
      $display("FAIL saturation: stall_cnt got %0d required %0d", stall_cnt, CNT_MAX);
    end
`else
    if (stall_cnt !== CNT_W'(0)) begin
      n_err++;
      $display("FAIL saturation: stall_cnt got %0d required 0", stall_cnt);
    end
`endif
    set_idle();
    run_cycle("sat_release");
  endtask

  initial begin
    #2;
    test_reset("reset");
    test_load_use();
    test_ex_forward();
    test_id_compare();
    test_stall_redirect();
    test_random(300);
    test_halt();
    test_reset("reset_mid_stall");
    test_random(100);
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
